// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one HD44780 4-bit bus between two requesters.
// Serializes each accepted byte into timed high/low nibble enable pulses.
module lcd_bus_arbiter #(
    parameter int unsigned EN_CYCLES   = 1,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned SLOW_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic       a_rs,
    input  logic [7:0] a_data,
    input  logic       a_nib,
    input  logic       a_lock,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic       b_rs,
    input  logic [7:0] b_data,
    input  logic       b_nib,
    input  logic       b_lock,
    output logic [1:0] owner,
    output logic       busy,
    output logic       en,
    output logic       rs,
    output logic [3:0] data
);
    localparam int unsigned MAX_EG  = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_EG > SLOW_CYCLES) ? MAX_EG : SLOW_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] EN_LAST   = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'((SLOW_CYCLES == 0) ? 0 : SLOW_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HI_EN, S_HI_GAP, S_LO_EN, S_LO_GAP, S_SLOW
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_rs, r_nib, r_lock, r_last_b;
    logic [7:0]       r_byte, w_byte_nxt;
    logic             r_en, r_busy, w_en_nxt, w_busy_nxt;
    logic [3:0]       r_data, w_data_nxt;
    logic [1:0]       r_owner, w_owner_nxt;
    logic             w_sel_a, w_sel_b, w_idle, w_accept, w_slow_cmd;
    logic             w_rs_in, w_nib_in, w_lock_in, w_lock_nxt, w_owner_b;
    logic [7:0]       w_data_in;

    // While locked only the previous grantee may win; otherwise alternate on ties.
    always_comb begin
        w_sel_a = 1'b0;
        w_sel_b = 1'b0;
        if (r_lock) begin
            w_sel_a = a_valid && !r_last_b;
            w_sel_b = b_valid && r_last_b;
        end else if (a_valid && b_valid) begin
            w_sel_a = r_last_b;
            w_sel_b = !r_last_b;
        end else begin
            w_sel_a = a_valid;
            w_sel_b = b_valid;
        end
    end

    assign w_idle    = (r_state == S_IDLE) && !reset;
    assign a_ready   = w_idle && w_sel_a;
    assign b_ready   = w_idle && w_sel_b;
    assign w_accept  = a_ready || b_ready;
    assign w_rs_in   = w_sel_b ? b_rs   : a_rs;
    assign w_data_in = w_sel_b ? b_data : a_data;
    assign w_nib_in  = w_sel_b ? b_nib  : a_nib;
    assign w_lock_in = w_sel_b ? b_lock : a_lock;

    assign w_slow_cmd = !r_rs && !r_nib &&
                        ((r_byte == 8'h01) || (r_byte == 8'h02) || (r_byte == 8'h03));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_byte_nxt  = w_accept ? w_data_in : r_byte;
        w_lock_nxt  = w_accept ? w_lock_in : r_lock;
        w_owner_b   = w_accept ? w_sel_b   : r_last_b;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = w_nib_in ? S_LO_EN : S_HI_EN;
            S_HI_EN:  if (r_cnt == EN_LAST) w_state_nxt = S_HI_GAP;
            S_HI_GAP: if (r_cnt == GAP_LAST) w_state_nxt = S_LO_EN;
            S_LO_EN:  if (r_cnt == EN_LAST) w_state_nxt = S_LO_GAP;
            S_LO_GAP: if (r_cnt == GAP_LAST)
                          w_state_nxt = (w_slow_cmd && (SLOW_CYCLES != 0)) ? S_SLOW : S_IDLE;
            S_SLOW:   if (r_cnt == SLOW_LAST) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if ((w_state_nxt != r_state) || (r_state == S_IDLE)) w_cnt_nxt = '0;

        // Pin outputs are registered from the next state so they align with it.
        w_en_nxt   = (w_state_nxt == S_HI_EN) || (w_state_nxt == S_LO_EN);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_HI_EN, S_HI_GAP: w_data_nxt = w_byte_nxt[7:4];
            S_LO_EN, S_LO_GAP: w_data_nxt = w_byte_nxt[3:0];
            default:           w_data_nxt = r_data;
        endcase
        w_owner_nxt = 2'b00;
        if (w_busy_nxt || w_lock_nxt) w_owner_nxt = w_owner_b ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rs     <= 1'b0;
            r_nib    <= 1'b0;
            r_lock   <= 1'b0;
            r_last_b <= 1'b1;
            r_byte   <= 8'h00;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_data   <= 4'h0;
            r_owner  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_byte  <= w_byte_nxt;
            r_lock  <= w_lock_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_data  <= w_data_nxt;
            r_owner <= w_owner_nxt;
            if (w_accept) begin
                r_rs     <= w_rs_in;
                r_nib    <= w_nib_in;
                r_last_b <= w_sel_b;
            end
        end
    end

    assign en    = r_en;
    assign rs    = r_rs;
    assign data  = r_data;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule
